// File: rtl/depth_approach_ctrl_pkg.sv
// Shared game constants for the depth approach path, LUT stage and renderer.
package depth_approach_ctrl_pkg;

  localparam int unsigned       DEPTH_W     = 13;
  localparam logic [12:0]       START_DEPTH = 13'h1F80;
  localparam int unsigned       SCALE_W     = 16;
  localparam logic [15:0]       SCALE_INIT  = 16'd256;
  localparam int unsigned       DEPTH_HIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_APPROACH = 2'd1,
    ST_HIT      = 2'd2
  } state_e;

endpackage

// File: rtl/depth_approach_ctrl_sat_add.sv
// Unsigned saturating adder: sum clamps to all-ones instead of wrapping.
module sat_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/depth_approach_ctrl.sv
// Steps one object from the far plane to the camera, one grate-sized step
// per frame, growing its sprite scale by the same amount.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no object in flight; depth parked at START_DEPTH
// APPROACH | object moving; each frame_tick subtracts grate from depth
// HIT      | single-cycle arrival marker, hit high, then back to IDLE
module depth_approach_ctrl #(
  parameter int unsigned          DEPTH_W     = depth_approach_ctrl_pkg::DEPTH_W,
  parameter logic [DEPTH_W-1:0]   START_DEPTH = depth_approach_ctrl_pkg::START_DEPTH,
  parameter int unsigned          SCALE_W     = depth_approach_ctrl_pkg::SCALE_W,
  parameter logic [SCALE_W-1:0]   SCALE_INIT  = depth_approach_ctrl_pkg::SCALE_INIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spawn,
  input  logic               abort,
  input  logic               frame_tick,
  input  logic [DEPTH_W-1:0] grate,
  output logic [DEPTH_W-1:0] depth,
  output logic [SCALE_W-1:0] scale,
  output logic               active,
  output logic               hit
);

  import depth_approach_ctrl_pkg::*;

  state_e             state_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [SCALE_W-1:0] scale_q;
  logic               active_q;
  logic               hit_q;

  logic [DEPTH_W-1:0] step_d;
  logic [DEPTH_W-1:0] depth_d;
  logic [SCALE_W-1:0] scale_d;
  logic               arrive_d;

  // A zero rate would stall the object forever, so it is treated as one.
  always_comb begin
    step_d   = (grate == '0) ? DEPTH_W'(1) : grate;
    arrive_d = (depth_q <= step_d);
    depth_d  = depth_q - step_d;
  end

  sat_add #(
    .W (SCALE_W)
  ) u_scale_add (
    .a_i   (scale_q),
    .b_i   (SCALE_W'(step_d)),
    .sum_o (scale_d)
  );

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state_q  <= ST_IDLE;
      depth_q  <= START_DEPTH;
      scale_q  <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          depth_q <= START_DEPTH;
          hit_q   <= 1'b0;
          if (spawn) begin
            state_q  <= ST_APPROACH;
            scale_q  <= SCALE_INIT;
            active_q <= 1'b1;
          end
        end
        ST_APPROACH: begin
          if (frame_tick) begin
            scale_q <= scale_d;
            if (arrive_d) begin
              state_q  <= ST_HIT;
              depth_q  <= DEPTH_W'(DEPTH_HIT);
              active_q <= 1'b0;
              hit_q    <= 1'b1;
            end else begin
              depth_q <= depth_d;
            end
          end
        end
        ST_HIT: begin
          state_q  <= ST_IDLE;
          depth_q  <= START_DEPTH;
          active_q <= 1'b0;
          hit_q    <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          depth_q  <= START_DEPTH;
          active_q <= 1'b0;
          hit_q    <= 1'b0;
        end
      endcase
    end
  end

  assign depth  = depth_q;
  assign scale  = scale_q;
  assign active = active_q;
  assign hit    = hit_q;

endmodule

// File: tb/tb_depth_approach_ctrl.sv
// Self-checking bench for depth_approach_ctrl: vector table, directed corners,
// LUT-driven full run and randomized traffic against a behavioural model.
module tb_depth_approach_ctrl;

  localparam int START = 8064;
  localparam int SMAX  = 65535;

  logic        clk = 1'b0;
  logic        reset, spawn, abort, frame_tick;
  logic [12:0] grate, grate_drv;
  logic        lut_on;
  logic [12:0] depth;
  logic [15:0] scale;
  logic        active, hit;

  int tests  = 0;
  int failed = 0;
  int hit_seen = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  depth_approach_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .spawn      (spawn),
    .abort      (abort),
    .frame_tick (frame_tick),
    .grate      (grate),
    .depth      (depth),
    .scale      (scale),
    .active     (active),
    .hit        (hit)
  );

  // Growth-rate LUT stand-in: rate rises as the object gets closer.
  function automatic int lut_fn(input int d);
    if (d >= START) return 2;
    return 2 + ((START - d) >> 6);
  endfunction

  assign grate = lut_on ? 13'(lut_fn(int'(depth))) : grate_drv;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic a, input logic t,
                     input logic [12:0] g);
    @(negedge clk);
    reset = r; spawn = s; abort = a; frame_tick = t; grate_drv = g;
    @(posedge clk);
    #1;
    if (hit) hit_seen++;
    if (hit && active) overlap++;
  endtask

  typedef struct {
    logic        r, s, a, t;
    logic [12:0] g;
    int          d, sc;
    logic        act, h;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int   m_depth, m_scale;
  bit   m_active, m_hit;

  task automatic model_step(input bit r, input bit s, input bit a, input bit t, input int g_in);
    int g;
    if (r || a) begin
      m_depth = START; m_scale = 0; m_active = 0; m_hit = 0;
    end else if (m_hit) begin
      m_hit = 0; m_depth = START;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_depth = START; m_scale = 256;
      end
    end else if (t) begin
      g = (g_in == 0) ? 1 : g_in;
      m_scale = (m_scale + g > SMAX) ? SMAX : m_scale + g;
      if (m_depth <= g) begin
        m_depth = 0; m_active = 0; m_hit = 1;
      end else begin
        m_depth = m_depth - g;
      end
    end
  endtask

  initial begin
    int prev_depth, n_ticks, sum_g, ref_ticks, ref_scale, d, g, decr_bad;
    bit done;
    reset = 1; spawn = 0; abort = 0; frame_tick = 0; grate_drv = '0; lut_on = 0;

    // r s a t g  depth scale act hit
    vecs.push_back('{1,0,0,0,    0, 8064,    0,0,0});
    vecs.push_back('{1,0,0,0,    0, 8064,    0,0,0});
    vecs.push_back('{0,0,0,1,    0, 8064,    0,0,0});
    vecs.push_back('{0,0,0,1,    0, 8064,    0,0,0});
    vecs.push_back('{0,0,0,1,    0, 8064,    0,0,0});
    vecs.push_back('{0,1,0,0,    0, 8064,  256,1,0});
    vecs.push_back('{0,0,0,1,    2, 8062,  258,1,0});
    vecs.push_back('{0,1,0,0,    5, 8062,  258,1,0});
    vecs.push_back('{0,0,0,1,    0, 8061,  259,1,0});
    vecs.push_back('{0,0,0,1, 7961,  100, 8220,1,0});
    vecs.push_back('{0,0,0,0,  127,  100, 8220,1,0});
    vecs.push_back('{0,0,0,1,  127,    0, 8347,0,1});
    vecs.push_back('{0,1,0,1,    9, 8064, 8347,0,0});
    vecs.push_back('{0,1,0,0,    0, 8064,  256,1,0});
    vecs.push_back('{0,0,1,1,   50, 8064,    0,0,0});
    vecs.push_back('{0,1,1,0,    0, 8064,    0,0,0});
    vecs.push_back('{0,1,0,0,    0, 8064,  256,1,0});
    vecs.push_back('{0,0,0,1, 8064,    0, 8320,0,1});
    vecs.push_back('{0,0,0,0,    0, 8064, 8320,0,0});
    vecs.push_back('{0,0,0,1,    3, 8064, 8320,0,0});
    vecs.push_back('{0,1,0,0,    0, 8064,  256,1,0});
    vecs.push_back('{0,0,0,1, 8063,    1, 8319,1,0});
    vecs.push_back('{0,0,0,1,    0,    0, 8320,0,1});
    vecs.push_back('{0,0,0,0,    0, 8064, 8320,0,0});
    vecs.push_back('{0,1,0,1,    0, 8064,  256,1,0});
    vecs.push_back('{0,0,0,1,   40, 8024,  296,1,0});
    vecs.push_back('{1,0,0,1,   10, 8064,    0,0,0});

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].t, vecs[i].g);
      chk($sformatf("vec%0d_depth", i), int'(depth), vecs[i].d);
      chk($sformatf("vec%0d_scale", i), int'(scale), vecs[i].sc);
      chk($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].act));
      chk($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].h));
    end

    // Saturation, then zero-rate progress
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    #1 dut.scale_q = 16'd65500;
    cyc(0, 0, 0, 1, 127);
    chk("sat_scale", int'(scale), 65535);
    chk("sat_depth", int'(depth), START - 127);
    cyc(0, 0, 0, 1, 0);
    chk("zero_rate_depth", int'(depth), START - 128);
    chk("zero_rate_scale", int'(scale), 65535);

    // Full run with LUT model attached
    ref_ticks = 0; ref_scale = 256; d = START;
    forever begin
      g = lut_fn(d);
      if (g == 0) g = 1;
      ref_ticks++;
      ref_scale = (ref_scale + g > SMAX) ? SMAX : ref_scale + g;
      if (d <= g) break;
      d = d - g;
    end

    cyc(1, 0, 0, 0, 0);
    lut_on = 1;
    hit_seen = 0;
    cyc(0, 1, 0, 0, 0);
    chk("run_spawn_active", int'(active), 1);
    n_ticks = 0; sum_g = 0; decr_bad = 0; done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      prev_depth = int'(depth);
      g = lut_fn(prev_depth);
      if (g == 0) g = 1;
      cyc(0, 0, 0, 1, 0);
      n_ticks++;
      sum_g += g;
      if (hit) done = 1;
      else if (int'(depth) >= prev_depth) decr_bad++;
    end
    chk("run_reached_hit", int'(done), 1);
    chk("run_depth_decreasing", decr_bad, 0);
    chk("run_tick_count", n_ticks, ref_ticks);
    chk("run_scale_vs_sum", int'(scale), (256 + sum_g > SMAX) ? SMAX : 256 + sum_g);
    chk("run_scale_vs_model", int'(scale), ref_scale);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 0);
    chk("run_hit_pulses", hit_seen, 1);
    chk("run_back_idle_depth", int'(depth), START);
    lut_on = 0;

    // Randomized traffic against the behavioural model
    cyc(1, 0, 0, 0, 0);
    m_depth = START; m_scale = 0; m_active = 0; m_hit = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r, s, a, t;
      int gv;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0: gv = 0;
        1: gv = $urandom_range(0, 8191);
        default: gv = $urandom_range(1, 300);
      endcase
      cyc(r, s, a, t, 13'(gv));
      model_step(r, s, a, t, gv);
      chk("rnd_depth", int'(depth), m_depth);
      chk("rnd_scale", int'(scale), m_scale);
      chk("rnd_active", int'(active), int'(m_active));
      chk("rnd_hit", int'(hit), int'(m_hit));
    end
    chk("hit_with_active", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
